// File: rtl/ltc_lane_aligner.sv
// LTC ADC lane aligner: bitslip frame-alignment FSM with lock monitor, plus lane-to-sample reassembly.
// Optional per-channel test-pattern error counters when LTC_LANE_PATTERN_CHECK_EN is defined.
module ltc_lane_aligner #(
  parameter int unsigned     NCH        = 2,
  parameter int unsigned     LANES      = 2,
  parameter int unsigned     SER        = 8,
  parameter logic [SER-1:0]  FR_PATTERN = 8'hF0,
  parameter int unsigned     SETTLE     = 3,
  parameter int unsigned     CONFIRM    = 4,
  parameter int unsigned     LOSS_CNT   = 8
`ifdef LTC_LANE_PATTERN_CHECK_EN
  , parameter logic [LANES*SER-1:0] TEST_PATTERN = 16'hB2E9
`endif
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         align_start_in,
  input  logic [SER-1:0]               fr_in,
  input  logic [NCH*LANES*SER-1:0]     data_in,
  output logic                         bitslip_out,
  output logic                         aligned_out,
  output logic                         align_err_out,
  output logic [$clog2(SER):0]         slip_cnt_out,
  output logic [NCH*LANES*SER-1:0]     adc_out,
  output logic                         valid_out
`ifdef LTC_LANE_PATTERN_CHECK_EN
  , input  logic                       chk_en_in,
  output logic [NCH*16-1:0]            pat_err_cnt_out
`endif
);

  localparam int unsigned W   = LANES * SER;
  localparam int unsigned SCW = $clog2(SER) + 1;
  localparam int unsigned WCW = $clog2(SETTLE + 1);
  localparam int unsigned MCW = $clog2(CONFIRM + 1);
  localparam int unsigned LCW = $clog2(LOSS_CNT + 1);

  localparam logic [SCW-1:0] SLIP_MAX     = SCW'(SER - 1);
  localparam logic [WCW-1:0] SETTLE_LAST  = WCW'(SETTLE - 1);
  localparam logic [MCW-1:0] CONFIRM_LAST = MCW'(CONFIRM - 1);
  localparam logic [LCW-1:0] LOSS_LAST    = LCW'(LOSS_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [MCW-1:0] match_q, match_d;
  logic [LCW-1:0] miss_q, miss_d;
  logic [SCW-1:0] slip_q, slip_d;
  logic           fr_match;

  assign fr_match = (fr_in == FR_PATTERN);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      slip_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      slip_q  <= slip_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    match_d       = match_q;
    miss_d        = miss_q;
    slip_d        = slip_q;
    bitslip_out   = (state_q == S_SLIP);
    aligned_out   = (state_q == S_LOCKED);
    align_err_out = (state_q == S_FAIL);
    slip_cnt_out  = slip_q;
    // A start request overrides every state, so a pending slip never stretches.
    if (align_start_in) begin
      state_d = S_WAIT;
      wait_d  = '0;
      match_d = '0;
      miss_d  = '0;
      slip_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (wait_q == SETTLE_LAST) begin
            state_d = S_CHECK;
            wait_d  = '0;
            match_d = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (fr_match) begin
            if (match_q == CONFIRM_LAST) begin
              state_d = S_LOCKED;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            state_d = (slip_q < SLIP_MAX) ? S_SLIP : S_FAIL;
          end
        end
        S_SLIP: begin
          slip_d  = slip_q + 1'b1;
          wait_d  = '0;
          state_d = S_WAIT;
        end
        S_LOCKED: begin
          if (fr_match) begin
            miss_d = '0;
          end else if (miss_q == LOSS_LAST) begin
            state_d = S_WAIT;
            wait_d  = '0;
            miss_d  = '0;
            slip_d  = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        S_FAIL: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  logic [NCH*W-1:0] data_q, adc_q, adc_d;
  logic             v1_q, valid_q;

  // Lane words are MSB-first in time; lanes interleave bit by bit into the sample.
  always_comb begin
    adc_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        for (int unsigned j = 0; j < SER; j++) begin
          adc_d[c*W + W-1 - (j*LANES + l)] = data_q[(c*LANES + l)*SER + SER-1 - j];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      data_q  <= '0;
      adc_q   <= '0;
      v1_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_in;
      adc_q   <= adc_d;
      v1_q    <= aligned_out;
      valid_q <= v1_q;
    end
  end

  assign adc_out   = adc_q;
  assign valid_out = valid_q;

`ifdef LTC_LANE_PATTERN_CHECK_EN
  logic              chk_en_q;
  logic [NCH*16-1:0] pat_cnt_q, pat_cnt_d;

  always_comb begin
    pat_cnt_d = pat_cnt_q;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (chk_en_in && !chk_en_q) begin
        pat_cnt_d[c*16 +: 16] = '0;
      end else if (chk_en_in && valid_q && (adc_q[c*W +: W] != TEST_PATTERN) &&
                   (pat_cnt_q[c*16 +: 16] != 16'hFFFF)) begin
        pat_cnt_d[c*16 +: 16] = pat_cnt_q[c*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      chk_en_q  <= 1'b0;
      pat_cnt_q <= '0;
    end else begin
      chk_en_q  <= chk_en_in;
      pat_cnt_q <= pat_cnt_d;
    end
  end

  assign pat_err_cnt_out = pat_cnt_q;
`endif

endmodule

// File: tb/tb_ltc_lane_aligner.sv
// Directed bench for ltc_lane_aligner: FSM scenarios plus a queue scoreboard on adc_out.
// Pattern-counter steps are included when LTC_LANE_PATTERN_CHECK_EN is defined.
module tb_ltc_lane_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        align_start;
  logic [7:0]  fr;
  logic [31:0] data;
  logic        bitslip;
  logic        aligned;
  logic        align_err;
  logic [3:0]  slip_cnt;
  logic [31:0] adc;
  logic        valid;
`ifdef LTC_LANE_PATTERN_CHECK_EN
  logic        chk_en;
  logic [31:0] pat_cnt;
`endif

  always #5 clk = ~clk;

  ltc_lane_aligner #(
    .NCH(2), .LANES(2), .SER(8), .FR_PATTERN(8'hF0),
    .SETTLE(3), .CONFIRM(4), .LOSS_CNT(8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .align_start_in(align_start),
    .fr_in(fr),
    .data_in(data),
    .bitslip_out(bitslip),
    .aligned_out(aligned),
    .align_err_out(align_err),
    .slip_cnt_out(slip_cnt),
    .adc_out(adc),
    .valid_out(valid)
`ifdef LTC_LANE_PATTERN_CHECK_EN
    , .chk_en_in(chk_en),
    .pat_err_cnt_out(pat_cnt)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          nslip = 0;
  int          last_slip = 0;
  int          min_gap = 1000;
  bit          sb_en = 1'b0;
  bit          fr_model = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sample bit b of a channel: k = W-1-b picks lane k%2, lane bit 7-k/2.
  function automatic logic [31:0] model(input logic [31:0] d);
    logic [31:0] r;
    int k;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      for (int b = 0; b < 16; b++) begin
        k = 15 - b;
        r[c*16 + b] = d[(c*2 + k % 2)*8 + 7 - k / 2];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] c0l0, input logic [7:0] c0l1,
                                       input logic [7:0] c1l0, input logic [7:0] c1l1);
    return {c1l1, c1l0, c0l1, c0l0};
  endfunction

  task automatic step();
    if (sb_en) exp_q.push_back(model(data));
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip === 1'b1) begin
      if (nslip > 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
      nslip++;
      last_slip = cyc;
      if (fr_model) fr = {fr[6:0], fr[7]};
    end
    if (sb_en && exp_q.size() >= 2) check("adc_sb", adc, exp_q.pop_front());
  endtask

  task automatic pulse_start();
    align_start = 1'b1;
    step();
    align_start = 1'b0;
  endtask

  task automatic wait_aligned(output int n);
    n = 0;
    while (aligned !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    align_start = 1'b0;
    fr = 8'h00;
    data = '0;
`ifdef LTC_LANE_PATTERN_CHECK_EN
    chk_en = 1'b0;
`endif

    // Reset with arbitrary inputs
    for (int i = 0; i < 3; i++) begin
      fr = 8'($urandom);
      data = $urandom;
      align_start = 1'($urandom);
      step();
      check("rst_bitslip", bitslip, 1'b0);
    end
    check("rst_aligned", aligned, 1'b0);
    check("rst_err", align_err, 1'b0);
    check("rst_slipcnt", slip_cnt, 4'd0);
    check("rst_adc", adc, 32'h0);
    check("rst_valid", valid, 1'b0);

    rst = 1'b1;
    align_start = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;

    // Static alignment
    fr = 8'hF0;
    data = pack(8'hDE, 8'h49, 8'h49, 8'hDE);
    nslip = 0;
    pulse_start();
    wait_aligned(n);
    check("static_lock_latency", n, 7);
    check("static_slips", nslip, 0);
    wait_valid(n);
    check("static_valid_delay", n, 2);
    check("static_adc_ch0", adc[15:0], 16'hB2E9);

    // Bitslip search: FR starts as F0 rotated right by 3
    fr = 8'h1E;
    fr_model = 1'b1;
    nslip = 0;
    min_gap = 1000;
    data = pack(8'h12, 8'h34, 8'h56, 8'h78);
    pulse_start();
    wait_aligned(n);
    check("search_aligned", aligned, 1'b1);
    check("search_slips", nslip, 3);
    check("search_slipcnt", slip_cnt, 4'd3);
    check("search_gap_ok", (min_gap >= 4), 1'b1);
    fr_model = 1'b0;

    // Failure: no valid frame
    fr = 8'h00;
    nslip = 0;
    pulse_start();
    n = 0;
    while (align_err !== 1'b1 && n < 200) begin
      data = $urandom;
      step();
      n++;
    end
    check("fail_err", align_err, 1'b1);
    check("fail_aligned", aligned, 1'b0);
    check("fail_slips", nslip, 7);
    check("fail_slipcnt", slip_cnt, 4'd7);
    fr = 8'hF0;
    pulse_start();
    check("fail_err_cleared", align_err, 1'b0);
    wait_aligned(n);
    check("relock_after_fail", aligned, 1'b1);
    wait_valid(n);

    // Lock loss tolerance: 7 bad frames keep lock
    fr = 8'h00;
    for (int i = 0; i < 7; i++) step();
    fr = 8'hF0;
    step();
    check("loss7_aligned", aligned, 1'b1);
    step();
    step();
    // 8 bad frames drop lock; valid follows two cycles later
    fr = 8'h00;
    for (int i = 0; i < 8; i++) step();
    check("loss8_aligned", aligned, 1'b0);
    check("loss8_slipcnt", slip_cnt, 4'd0);
    check("loss8_valid_d0", valid, 1'b1);
    fr = 8'hF0;
    step();
    check("loss8_valid_d1", valid, 1'b1);
    step();
    check("loss8_valid_d2", valid, 1'b0);
    wait_aligned(n);
    check("auto_realign", aligned, 1'b1);

    // Restart mid-WAIT clears slip count
    fr = 8'h00;
    pulse_start();
    n = 0;
    while (slip_cnt !== 4'd2 && n < 100) begin
      step();
      n++;
    end
    check("midwait_slipcnt", slip_cnt, 4'd2);
    pulse_start();
    check("midwait_restart_slipcnt", slip_cnt, 4'd0);
    check("midwait_restart_bitslip", bitslip, 1'b0);

`ifdef LTC_LANE_PATTERN_CHECK_EN
    fr = 8'hF0;
    data = pack(8'hDE, 8'h49, 8'hDE, 8'h49);
    pulse_start();
    wait_aligned(n);
    wait_valid(n);
    check("pat_valid", valid, 1'b1);
    step();
    step();
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pat_clean_ch0", pat_cnt[15:0], 16'd0);
    data = pack(8'hDE, 8'h48, 8'hDE, 8'h49);
    step();
    data = pack(8'hDE, 8'h49, 8'hDE, 8'h49);
    for (int i = 0; i < 5; i++) step();
    check("pat_cnt_ch0", pat_cnt[15:0], 16'd1);
    check("pat_cnt_ch1", pat_cnt[31:16], 16'd0);
`endif

    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
